fp_div_ctrl: RTL and testbench

//  Issue/retire controller that wraps the pipelined fp_division core. Accepts operand pairs
//  on a valid/ready handshake and drives them to the core. Tracks the core's fixed latency
//  and classifies operands: zero, inf, NaN, exponent range. Substitutes IEEE-754 special

---
 rtl/fp_div_ctrl.sv | 137 +++++++++++++
 tb/tb_fp_div_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_ctrl.sv
// Issue/retire controller around a fixed-latency IEEE-754 single divider core.
// Classifies operands, substitutes special results, and buffers retirements in a credit-limited FIFO.
module fp_div_ctrl #(
    parameter int DIV_LAT = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_c,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_flags
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        valid;
        logic        ovr;
        logic [31:0] ovr_val;
        logic [3:0]  flags;
    } stage_t;

    stage_t        pipe_q [DIV_LAT];
    stage_t        pipe_d [DIV_LAT];
    logic [35:0]   mem_q  [DEPTH];
    logic [35:0]   mem_d  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q, fill_d, cnt_q, cnt_d;

    logic              issue, pop, push;
    logic              sign;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic signed [9:0] exp_est;
    logic [31:0]       push_data;
    stage_t            new_stage;
    stage_t            retire;

    assign div_a     = op_a;
    assign div_b     = op_b;
    assign op_ready  = (cnt_q < CW'(DEPTH));
    assign res_valid = (fill_q != '0);
    assign {res_flags, res_data} = mem_q[rd_ptr_q];

    assign issue  = op_valid & op_ready;
    assign pop    = res_valid & res_ready;
    assign retire = pipe_q[DIV_LAT-1];
    assign push   = retire.valid;

    always_comb begin
        a_zero  = (op_a[30:23] == 8'd0);
        a_inf   = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
        a_nan   = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
        b_zero  = (op_b[30:23] == 8'd0);
        b_inf   = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
        b_nan   = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
        sign    = op_a[31] ^ op_b[31];
        // Quotient exponent, one lower when the dividend fraction is the smaller one
        exp_est = $signed({2'b00, op_a[30:23]}) - $signed({2'b00, op_b[30:23]}) + 10'sd127
                  - $signed({9'd0, (op_a[22:0] < op_b[22:0])});

        new_stage       = '0;
        new_stage.valid = issue;
        new_stage.ovr   = 1'b1;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            new_stage.ovr_val = 32'h7FC0_0000;
            new_stage.flags   = 4'b1000;
        end else if (a_inf) begin
            new_stage.ovr_val = {sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            new_stage.ovr_val = {sign, 8'hFF, 23'd0};
            new_stage.flags   = 4'b0100;
        end else if (a_zero | b_inf) begin
            new_stage.ovr_val = {sign, 31'd0};
        end else if (exp_est >= 10'sd255) begin
            new_stage.ovr_val = {sign, 8'hFF, 23'd0};
            new_stage.flags   = 4'b0010;
        end else if (exp_est <= 10'sd0) begin
            new_stage.ovr_val = {sign, 31'd0};
            new_stage.flags   = 4'b0001;
        end else begin
            new_stage.ovr = 1'b0;
        end

        pipe_d[0] = new_stage;
        for (int i = 1; i < DIV_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        push_data = retire.ovr ? retire.ovr_val : div_c;
        // The core's result lines up with the entry leaving the last tracking stage
        if (push) begin
            mem_d[wr_ptr_q] = {retire.flags, push_data};
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        fill_d = fill_q + CW'(push) - CW'(pop);
        cnt_d  = cnt_q + CW'(issue) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIV_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
        end else begin
            pipe_q   <= pipe_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fp_div_ctrl.sv
// Self-checking bench for fp_div_ctrl: models the divider core, directed special cases,
// credit/backpressure, random traffic against a queue-based reference, and mid-flight reset.
module tb_fp_div_ctrl;
    localparam int DIV_LAT = 2;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        op_ready, res_valid;
    logic [31:0] div_a, div_b, div_c, res_data;
    logic [3:0]  res_flags;
    logic [31:0] core_s1, core_s2;

    int          checks   = 0;
    int          failures = 0;
    logic [35:0] exp_q [$];

    fp_div_ctrl #(.DIV_LAT(DIV_LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_c     (div_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flags (res_flags)
    );

    always #5 clk = ~clk;

    // Truncating divide of two normal numbers, as the core would compute it
    function automatic logic [31:0] core_div(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] ma, mb, q;
        int          e;
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (ma >= mb) begin
            q = (ma << 23) / mb;
        end else begin
            q = (ma << 24) / mb;
            e = e - 1;
        end
        return {a[31] ^ b[31], e[7:0], q[22:0]};
    endfunction

    // Two-stage core: operands sampled on the issue edge, result visible after the next edge
    always @(posedge clk) begin
        core_s1 <= core_div(div_a, div_b);
        core_s2 <= core_s1;
    end
    assign div_c = core_s2;

    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e;
        logic        s, za, zb, ia, ib, na, nb;
        logic [31:0] inf_v, zero_v;
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        s      = a[31] ^ b[31];
        za     = (ea == 0);
        zb     = (eb == 0);
        ia     = (ea == 255) && (a[22:0] == 23'd0);
        ib     = (eb == 255) && (b[22:0] == 23'd0);
        na     = (ea == 255) && !ia;
        nb     = (eb == 255) && !ib;
        inf_v  = {s, 8'hFF, 23'd0};
        zero_v = {s, 31'd0};
        if (na || nb || (za && zb) || (ia && ib)) return {4'b1000, 32'h7FC0_0000};
        if (ia) return {4'b0000, inf_v};
        if (zb) return {4'b0100, inf_v};
        if (za || ib) return {4'b0000, zero_v};
        e = ea - eb + 127 - ((a[22:0] < b[22:0]) ? 1 : 0);
        if (e >= 255) return {4'b0010, inf_v};
        if (e <= 0) return {4'b0001, zero_v};
        return {4'b0000, core_div(a, b)};
    endfunction

    function automatic logic [31:0] rand_fp(input bit specials);
        int          k;
        logic [31:0] v;
        k = specials ? int'($urandom_range(0, 5)) : 9;
        v = $urandom;
        case (k)
            0: v[30:23] = 8'd0;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3: v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(64, 190));
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the negedge with this cycle's inputs applied; models the credit and retire order
    task automatic sb_step(input string tag);
        logic [35:0] e;
        check({tag, "_op_ready"}, 36'(op_ready), 36'(exp_q.size() < DEPTH));
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check({tag, "_spurious"}, 36'(res_valid), 36'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_result"}, {res_flags, res_data}, e);
            end
        end
        if (op_valid && op_ready) exp_q.push_back(ref_div(op_a, op_b));
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [35:0] expv);
        int lat;
        op_a = a; op_b = b; op_valid = 1'b1; res_ready = 1'b1;
        check({tag, "_ready"}, 36'(op_ready), 36'd1);
        tick();
        op_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 36'(lat), 36'(DIV_LAT + 1));
        check({tag, "_result"}, {res_flags, res_data}, expv);
        tick();
        check({tag, "_empty"}, 36'(res_valid), 36'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int pops;
        rst = 1'b1;
        @(negedge clk);
        check("rst_op_ready", 36'(op_ready), 36'd1);
        check("rst_res_valid", 36'(res_valid), 36'd0);
        check("rst_res_data", 36'(res_data), 36'd0);
        check("rst_res_flags", 36'(res_flags), 36'd0);
        rst = 1'b0;
        tick();

        directed("t1_6div2", 32'h40C0_0000, 32'h4000_0000, 36'h0_4040_0000);
        directed("t2_divzero", 32'h3F80_0000, 32'h0000_0000, 36'h4_7F80_0000);
        directed("t2_zero_zero", 32'h8000_0000, 32'h0000_0000, 36'h8_7FC0_0000);
        directed("t3_overflow", 32'h7F00_0000, 32'h0080_0000, 36'h2_7F80_0000);
        directed("t3_underflow", 32'h0080_0000, 32'h7F00_0000, 36'h1_0000_0000);
        directed("inf_div_fin", 32'hFF80_0000, 32'h3F80_0000, 36'h0_FF80_0000);

        // Credit limit under full backpressure
        res_ready = 1'b0; op_valid = 1'b1; issued = 0;
        for (int i = 0; i < 10; i++) begin
            op_a = rand_fp(1'b0); op_b = rand_fp(1'b0);
            if (op_valid && op_ready) issued++;
            sb_step("t4_fill");
            tick();
        end
        check("t4_issues", 36'(issued), 36'(DEPTH));
        check("t4_op_ready_low", 36'(op_ready), 36'd0);
        op_valid = 1'b0; res_ready = 1'b1; pops = 0;
        if (res_valid) pops++;
        sb_step("t4_pop");
        tick();
        check("t4_op_ready_back", 36'(op_ready), 36'd1);
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            if (res_valid) pops++;
            sb_step("t4_pop");
            tick();
        end
        check("t4_pops", 36'(pops), 36'(DEPTH));
        check("t4_drained", 36'(res_valid), 36'd0);

        // Random normal traffic, then mixed specials, with random backpressure
        for (int phase = 0; phase < 2; phase++) begin
            int target;
            target = (phase == 0) ? 16 : 24;
            issued = 0;
            for (int c = 0; c < 400 && (issued < target || exp_q.size() > 0); c++) begin
                op_valid  = (issued < target);
                op_a      = rand_fp(phase == 1);
                op_b      = rand_fp(phase == 1);
                res_ready = 1'($urandom_range(0, 1));
                if (op_valid && op_ready) issued++;
                sb_step(phase == 0 ? "t5_norm" : "t5_mixed");
                tick();
            end
            op_valid = 1'b0;
            check("t5_issued", 36'(issued), 36'(target));
            check("t5_no_leftover", 36'(res_valid), 36'd0);
            check("t5_credit_free", 36'(op_ready), 36'd1);
        end

        // Reset with two results buffered and two still in the core
        res_ready = 1'b0; op_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_a = rand_fp(1'b0); op_b = rand_fp(1'b0);
            sb_step("t6_fill");
            tick();
        end
        op_valid = 1'b0;
        check("t6_buffered", 36'(res_valid), 36'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("t6_res_valid", 36'(res_valid), 36'd0);
        check("t6_op_ready", 36'(op_ready), 36'd1);
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t6_no_stale", 36'(res_valid), 36'd0);
            tick();
        end
        directed("t6_after_rst", 32'h40C0_0000, 32'h4000_0000, 36'h0_4040_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
